// File: rtl/muldiv_pkg.sv
// Shared types and default sizes for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_REG_ADDR_W = 2;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request and register-file write bundle between the issuing stage and muldiv_unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
);

    logic                  start;
    muldiv_op_t            op;
    logic [WIDTH-1:0]      operand_a;
    logic [WIDTH-1:0]      operand_b;
    logic [REG_ADDR_W-1:0] dest_hi;
    logic [REG_ADDR_W-1:0] dest_lo;

    logic                  busy;
    logic                  done;
    logic                  div_by_zero;
    logic [2*WIDTH-1:0]    write_data;
    logic [REG_ADDR_W-1:0] write_reg1;
    logic [REG_ADDR_W-1:0] write_reg2;
    logic                  write_en1;
    logic                  write_en2;

    modport master (
        output start, op, operand_a, operand_b, dest_hi, dest_lo,
        input  busy, done, div_by_zero, write_data,
               write_reg1, write_reg2, write_en1, write_en2
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_hi, dest_lo,
        output busy, done, div_by_zero, write_data,
               write_reg1, write_reg2, write_en1, write_en2
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the {hi, lo} accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  muldiv_op_t         op,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] trial;

    assign hi = acc[2*WIDTH-1:WIDTH];
    assign lo = acc[WIDTH-1:0];

    // The multiply keeps the add carry so it shifts back into the top bit;
    // the divide's remainder never exceeds WIDTH bits once it is below the divisor.
    assign sum       = {1'b0, hi} + {1'b0, divisor};
    assign rem_shift = {hi, lo[WIDTH-1]};
    assign trial     = rem_shift[WIDTH-1:0] - divisor;

    always_comb begin
        acc_next = '0;
        if (op == OP_MUL) begin
            if (lo[0]) begin
                acc_next = {sum, lo[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, hi, lo[WIDTH-1:1]};
            end
        end else if (rem_shift >= {1'b0, divisor}) begin
            acc_next = {trial, lo[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {rem_shift[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide feeding the register file's 16-bit write port.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int              CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
    localparam logic [1:0]      ST_IDLE = 2'(S_IDLE);
    localparam logic [1:0]      ST_RUN  = 2'(S_RUN);
    localparam logic [1:0]      ST_DONE = 2'(S_DONE);

    logic [1:0]            state;
    logic [CNT_W-1:0]      count;
    muldiv_op_t            op_q;
    logic [WIDTH-1:0]      divisor_q;
    logic [2*WIDTH-1:0]    acc;
    logic [2*WIDTH-1:0]    acc_next;
    logic [REG_ADDR_W-1:0] dest_hi_q;
    logic [REG_ADDR_W-1:0] dest_lo_q;
    logic [2*WIDTH-1:0]    result_q;
    logic [REG_ADDR_W-1:0] write_reg1_q;
    logic [REG_ADDR_W-1:0] write_reg2_q;
    logic                  div_by_zero_q;

    muldiv_step #(.WIDTH(WIDTH)) step (
        .op       (op_q),
        .acc      (acc),
        .divisor  (divisor_q),
        .acc_next (acc_next)
    );

    // Both operations start from {0, a}: the multiply's empty upper half and
    // the divide's zero remainder with the dividend as the initial quotient.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            op_q          <= OP_MUL;
            divisor_q     <= '0;
            acc           <= '0;
            dest_hi_q     <= '0;
            dest_lo_q     <= '0;
            result_q      <= '0;
            write_reg1_q  <= '0;
            write_reg2_q  <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state         <= ST_RUN;
                        count         <= '0;
                        op_q          <= bus.op;
                        divisor_q     <= bus.operand_b;
                        acc           <= {{WIDTH{1'b0}}, bus.operand_a};
                        dest_hi_q     <= bus.dest_hi;
                        dest_lo_q     <= bus.dest_lo;
                        div_by_zero_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    // Results are registered here so they are settled by the
                    // register file's negedge write inside the DONE cycle.
                    if (count == LAST) begin
                        state         <= ST_DONE;
                        result_q      <= acc_next;
                        write_reg1_q  <= dest_hi_q;
                        write_reg2_q  <= dest_lo_q;
                        div_by_zero_q <= (op_q == OP_DIV) && (divisor_q == '0);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);
    assign bus.write_en1   = (state == ST_DONE);
    assign bus.write_en2   = (state == ST_DONE);
    assign bus.write_data  = result_q;
    assign bus.write_reg1  = write_reg1_q;
    assign bus.write_reg2  = write_reg2_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations vs. an arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W  = 8;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W), .REG_ADDR_W(RW)) bus ();

    muldiv_unit #(.WIDTH(W), .REG_ADDR_W(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result straight from integer arithmetic.
    function automatic logic [15:0] refResult(input muldiv_op_t op, input logic [7:0] a, input logic [7:0] b);
        int p;
        int q;
        int r;
        if (op == OP_MUL) begin
            p = int'(a) * int'(b);
            return p[15:0];
        end
        if (b == 8'd0) return {a, 8'hFF};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r[7:0], q[7:0]};
    endfunction

    task automatic scrambleInputs();
        bus.op        = muldiv_op_t'($urandom_range(0, 1));
        bus.operand_a = 8'($urandom);
        bus.operand_b = 8'($urandom);
        bus.dest_hi   = 2'($urandom);
        bus.dest_lo   = 2'($urandom);
    endtask

    task automatic applyStimulus(input string tag, input muldiv_op_t op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [1:0] hi, input logic [1:0] lo,
                                 input bit restartAtE3, input bit resetAtE4);
        logic [15:0] expData;
        int edgeIdx;
        int busyCount;
        int doneCount;
        int enCount;
        expData = refResult(op, a, b);

        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_hi   = hi;
        bus.dest_lo   = lo;
        @(negedge clk);
        bus.start = 1'b0;
        edgeIdx   = 0;
        busyCount = 0;
        checkOutput({tag, " dbz_clear"}, 32'(bus.div_by_zero), 32'd0);

        if (resetAtE4) begin
            while (edgeIdx < 3) begin
                scrambleInputs();
                @(negedge clk);
                edgeIdx++;
            end
            reset = 1'b1;
            @(negedge clk);
            checkOutput({tag, " rst_busy"}, 32'(bus.busy), 32'd0);
            checkOutput({tag, " rst_done"}, 32'(bus.done), 32'd0);
            checkOutput({tag, " rst_we"}, 32'({bus.write_en1, bus.write_en2}), 32'd0);
            checkOutput({tag, " rst_data"}, 32'(bus.write_data), 32'd0);
            reset     = 1'b0;
            doneCount = 0;
            enCount   = 0;
            repeat (12) begin
                @(negedge clk);
                doneCount += int'(bus.done);
                enCount   += int'(bus.write_en1) + int'(bus.write_en2);
            end
            checkOutput({tag, " rst_no_done"}, 32'(doneCount), 32'd0);
            checkOutput({tag, " rst_no_we"}, 32'(enCount), 32'd0);
            return;
        end

        while (bus.done !== 1'b1 && edgeIdx < 20) begin
            busyCount += int'(bus.busy);
            scrambleInputs();
            bus.start = restartAtE3 && (edgeIdx == 2);
            @(negedge clk);
            edgeIdx++;
        end
        bus.start = 1'b0;
        busyCount += int'(bus.busy);

        checkOutput({tag, " done"}, 32'(bus.done), 32'd1);
        checkOutput({tag, " latency"}, 32'(edgeIdx), 32'd8);
        checkOutput({tag, " busy_cycles"}, 32'(busyCount), 32'd9);
        checkOutput({tag, " data"}, 32'(bus.write_data), 32'(expData));
        checkOutput({tag, " dbz"}, 32'(bus.div_by_zero), 32'((op == OP_DIV) && (b == 8'd0)));
        checkOutput({tag, " reg1"}, 32'(bus.write_reg1), 32'(hi));
        checkOutput({tag, " reg2"}, 32'(bus.write_reg2), 32'(lo));
        checkOutput({tag, " we"}, 32'({bus.write_en1, bus.write_en2}), 32'd3);

        doneCount = 0;
        enCount   = 0;
        repeat (12) begin
            @(negedge clk);
            scrambleInputs();
            doneCount += int'(bus.done);
            enCount   += int'(bus.write_en1) + int'(bus.write_en2);
        end
        checkOutput({tag, " single_done"}, 32'(doneCount), 32'd0);
        checkOutput({tag, " single_we"}, 32'(enCount), 32'd0);
        checkOutput({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " hold_data"}, 32'(bus.write_data), 32'(expData));
        checkOutput({tag, " hold_regs"}, 32'({bus.write_reg1, bus.write_reg2}), 32'({hi, lo}));
        checkOutput({tag, " hold_dbz"}, 32'(bus.div_by_zero), 32'((op == OP_DIV) && (b == 8'd0)));
    endtask

    initial begin
        muldiv_op_t rop;
        logic [7:0] ra;
        logic [7:0] rb;

        reset     = 1'b1;
        bus.start = 1'b0;
        scrambleInputs();
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset dbz", 32'(bus.div_by_zero), 32'd0);
        checkOutput("reset we", 32'({bus.write_en1, bus.write_en2}), 32'd0);
        checkOutput("reset data", 32'(bus.write_data), 32'd0);
        checkOutput("reset regs", 32'({bus.write_reg1, bus.write_reg2}), 32'd0);
        reset = 1'b0;

        applyStimulus("mul13x11", OP_MUL, 8'd13, 8'd11, 2'd2, 2'd3, 1'b0, 1'b0);
        applyStimulus("mul255x255", OP_MUL, 8'd255, 8'd255, 2'd0, 2'd1, 1'b0, 1'b0);
        applyStimulus("div200by7", OP_DIV, 8'd200, 8'd7, 2'd1, 2'd0, 1'b0, 1'b0);
        applyStimulus("div5Aby0", OP_DIV, 8'h5A, 8'd0, 2'd3, 2'd2, 1'b0, 1'b0);
        applyStimulus("mul_restart", OP_MUL, 8'd13, 8'd11, 2'd2, 2'd3, 1'b1, 1'b0);
        applyStimulus("div_reset", OP_DIV, 8'd200, 8'd7, 2'd1, 2'd2, 1'b0, 1'b1);
        applyStimulus("div_after_rst", OP_DIV, 8'd99, 8'd10, 2'd2, 2'd2, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rop = muldiv_op_t'($urandom_range(0, 1));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            applyStimulus($sformatf("rand%0d", i), rop, ra, rb, 2'($urandom), 2'($urandom), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
